// File: rtl/abc_compressor_pkg.sv
// Shared widths, code-type encodings and k-selection helpers for the ABC ECG compressor.
package abc_compressor_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int DELTA_W   = SAMPLE_W + 1;
  localparam int RUN_W     = 6;
  localparam int IDX_W     = 3;
  localparam int N_SAMPLES = 8;
  localparam int SUM_W     = 20;
  localparam int UNARY_W   = 7;
  localparam int K_W       = 3;
  localparam int WORD_W    = UNARY_W + 5;
  localparam int G1_W      = UNARY_W + 3;
  localparam int G2_W      = UNARY_W + 4;
  localparam int G3_W      = WORD_W;
  localparam int ANSR_W    = RUN_W + 2;
  localparam int Q_MAX     = UNARY_W - 1;

  localparam logic [SUM_W-1:0]   K_TH_LO    = 20'd128;
  localparam logic [SUM_W-1:0]   K_TH_HI    = 20'd256;
  localparam logic [K_W-1:0]     K_SMALL    = 3'd3;
  localparam logic [K_W-1:0]     K_MID      = 3'd4;
  localparam logic [K_W-1:0]     K_LARGE    = 3'd5;
  localparam logic [RUN_W-1:0]   RUN_MAX    = '1;
  localparam logic [1:0]         RUN_TAG    = 2'b10;
  localparam logic [IDX_W-1:0]   IDX_LAST   = '1;
  localparam logic [UNARY_W-1:0] UNARY_ONES = '1;

  typedef enum logic [1:0] {
    CODE_ZERO   = 2'd0,
    CODE_GR     = 2'd1,
    CODE_ESC    = 2'd2,
    CODE_UNUSED = 2'd3
  } code_e;

  // Sign-extend both operands so the 17-bit difference never overflows.
  function automatic logic signed [DELTA_W-1:0] delta(input logic signed [SAMPLE_W-1:0] cur,
                                                      input logic signed [SAMPLE_W-1:0] prev);
    return {cur[SAMPLE_W-1], cur} - {prev[SAMPLE_W-1], prev};
  endfunction

  function automatic logic [DELTA_W-1:0] abs_delta(input logic signed [DELTA_W-1:0] d);
    return d[DELTA_W-1] ? -d : d;
  endfunction

  function automatic logic [K_W-1:0] k_from_sum(input logic [SUM_W-1:0] s);
    if (s < K_TH_LO) return K_SMALL;
    if (s < K_TH_HI) return K_MID;
    return K_LARGE;
  endfunction

endpackage

// File: rtl/abc_compressor_if.sv
// Block-level bus of the compressor: one 8-sample block in, one coded sample out per cycle.
interface abc_compressor_if
  import abc_compressor_pkg::*;
();

  // No valid/ready: the source holds a block stable for 8 cycles starting at idx 0,
  // and every cycle the compressor emits the registered result of one sample.
  logic signed [SAMPLE_W-1:0] x1, x2, x3, x4, x5, x6, x7, x8;
  logic signed [SAMPLE_W-1:0] b;
  logic [RUN_W-1:0]           cin;
  logic [RUN_W-1:0]           cout;
  logic [1:0]                 a;
  logic [K_W-1:0]             k;
  logic [ANSR_W-1:0]          ansr;
  logic [G1_W-1:0]            ansg1;
  logic [G2_W-1:0]            ansg2;
  logic [G3_W-1:0]            ansg3;
  logic [IDX_W-1:0]           idx;

  modport master (
    output x1, x2, x3, x4, x5, x6, x7, x8, b, cin,
    input  cout, a, k, ansr, ansg1, ansg2, ansg3, idx
  );

  modport slave (
    input  x1, x2, x3, x4, x5, x6, x7, x8, b, cin,
    output cout, a, k, ansr, ansg1, ansg2, ansg3, idx
  );

endinterface

// File: rtl/abc_compressor_gr_encoder.sv
// Combinational Golomb-Rice coder for one delta: zigzag map, unary quotient, k-bit remainder.
module abc_gr_encoder
  import abc_compressor_pkg::*;
(
  input  logic signed [DELTA_W-1:0] d_i,
  input  logic [K_W-1:0]            k_i,
  output code_e                     a_o,
  output logic [WORD_W-1:0]         word_o
);

  logic [DELTA_W:0]   u;
  logic [DELTA_W:0]   q;
  logic [UNARY_W-1:0] f;

  always_comb begin
    // Zigzag: -2d-1 is the bitwise inverse of 2d, so negatives need no adder.
    u      = d_i[DELTA_W-1] ? ~{d_i, 1'b0} : {d_i, 1'b0};
    q      = u >> k_i;
    f      = ~(UNARY_ONES >> q[2:0]);
    a_o    = CODE_ZERO;
    word_o = '0;
    if (d_i != '0) begin
      if (q <= (DELTA_W + 1)'(Q_MAX)) begin
        a_o = CODE_GR;
        case (k_i)
          K_SMALL: word_o = {{(WORD_W - G1_W){1'b0}}, f, u[2:0]};
          K_MID:   word_o = {{(WORD_W - G2_W){1'b0}}, f, u[3:0]};
          default: word_o = {f, u[4:0]};
        endcase
      end else begin
        a_o = CODE_ESC;
      end
    end
  end

endmodule

// File: rtl/abc_compressor.sv
// ABC compressor top: captures an 8-sample block at idx 0, codes one sample per cycle
// with zero-run tracking and block-wide Golomb-Rice parameter selection.
module abc_compressor
  import abc_compressor_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  abc_compressor_if.slave bus
);

  logic [IDX_W-1:0]           idx_q;
  logic signed [SAMPLE_W-1:0] x_q  [N_SAMPLES];
  logic signed [SAMPLE_W-1:0] x_in [N_SAMPLES];
  logic signed [DELTA_W-1:0]  d_port [N_SAMPLES];
  logic signed [DELTA_W-1:0]  d_cur;
  logic [SUM_W-1:0]           sum_abs;
  logic [K_W-1:0]             k_port, k_q, k_d;
  logic [RUN_W-1:0]           run_q, run_d, run_in, run_inc, cout_q;
  logic [ANSR_W-1:0]          ansr_q, ansr_d;
  logic [G1_W-1:0]            g1_q, g1_d;
  logic [G2_W-1:0]            g2_q, g2_d;
  logic [G3_W-1:0]            g3_q, g3_d;
  code_e                      a_q, enc_a;
  logic [WORD_W-1:0]          enc_word;

  assign x_in[0] = bus.x1;
  assign x_in[1] = bus.x2;
  assign x_in[2] = bus.x3;
  assign x_in[3] = bus.x4;
  assign x_in[4] = bus.x5;
  assign x_in[5] = bus.x6;
  assign x_in[6] = bus.x7;
  assign x_in[7] = bus.x8;

  // k covers the whole block, so all eight deltas are formed from the ports at idx 0.
  always_comb begin
    d_port[0] = delta(x_in[0], bus.b);
    sum_abs   = SUM_W'(abs_delta(d_port[0]));
    for (int j = 1; j < N_SAMPLES; j++) begin
      d_port[j] = delta(x_in[j], x_in[j-1]);
      sum_abs   = sum_abs + SUM_W'(abs_delta(d_port[j]));
    end
    k_port = k_from_sum(sum_abs);
  end

  always_comb begin
    if (idx_q == '0) begin
      d_cur  = d_port[0];
      k_d    = k_port;
      run_in = bus.cin;
    end else begin
      d_cur  = delta(x_q[idx_q], x_q[idx_q - IDX_W'(1)]);
      k_d    = k_q;
      run_in = run_q;
    end
    run_inc = run_in + RUN_W'(1);
    run_d   = '0;
    ansr_d  = '0;
    if (d_cur == '0) begin
      if (run_inc == RUN_MAX) ansr_d = {RUN_TAG, RUN_MAX};
      else                    run_d  = run_inc;
    end else if (run_in != '0) begin
      ansr_d = {RUN_TAG, run_in};
    end
  end

  abc_gr_encoder u_enc (
    .d_i    (d_cur),
    .k_i    (k_d),
    .a_o    (enc_a),
    .word_o (enc_word)
  );

  assign g1_d = (k_d == K_SMALL) ? enc_word[G1_W-1:0] : '0;
  assign g2_d = (k_d == K_MID)   ? enc_word[G2_W-1:0] : '0;
  assign g3_d = (k_d == K_LARGE) ? enc_word           : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      run_q  <= '0;
      k_q    <= '0;
      cout_q <= '0;
      a_q    <= CODE_ZERO;
      ansr_q <= '0;
      g1_q   <= '0;
      g2_q   <= '0;
      g3_q   <= '0;
      for (int j = 0; j < N_SAMPLES; j++) x_q[j] <= '0;
    end else begin
      idx_q  <= idx_q + IDX_W'(1);
      if (idx_q == '0) x_q <= x_in;
      k_q    <= k_d;
      run_q  <= run_d;
      a_q    <= enc_a;
      ansr_q <= ansr_d;
      g1_q   <= g1_d;
      g2_q   <= g2_d;
      g3_q   <= g3_d;
      if (idx_q == IDX_LAST) cout_q <= run_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.k     = k_q;
  assign bus.ansr  = ansr_q;
  assign bus.ansg1 = g1_q;
  assign bus.ansg2 = g2_q;
  assign bus.ansg3 = g3_q;
  assign bus.cout  = cout_q;
  assign bus.idx   = idx_q;

endmodule

// File: tb/tb_abc_compressor.sv
// Bench for abc_compressor: directed vectors, chained random blocks and a mid-block reset,
// checked against a behavioural block model through an expected-result queue.
module tb_abc_compressor;

  localparam int REC_W = 49;

  logic clk;
  logic rst_n;

  abc_compressor_if bus ();

  abc_compressor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [REC_W-1:0] exp_q [$];
  logic [REC_W-1:0] obs_rec [8];
  int blk_x [8];
  int blk_b;
  int blk_cin;
  int exp_cout;
  int prev_cout;
  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [REC_W-1:0] pack(int idx, int a, int kk, int ansr, int g1, int g2, int g3);
    return {3'(idx), 2'(a), 3'(kk), 8'(ansr), 10'(g1), 11'(g2), 12'(g3)};
  endfunction

  function automatic logic [REC_W-1:0] obs_now();
    return {bus.idx, bus.a, bus.k, bus.ansr, bus.ansg1, bus.ansg2, bus.ansg3};
  endfunction

  // Behavioural reference: integer arithmetic, one block at a time.
  task automatic model_block();
    int s, kk, run, d, prev, u, q, r, f, word, ansr, a, g1, g2, g3;
    s = 0;
    prev = blk_b;
    for (int j = 0; j < 8; j++) begin
      d = blk_x[j] - prev;
      s += (d < 0) ? -d : d;
      prev = blk_x[j];
    end
    kk = (s < 128) ? 3 : (s < 256) ? 4 : 5;
    run = blk_cin;
    prev = blk_b;
    for (int j = 0; j < 8; j++) begin
      d = blk_x[j] - prev;
      prev = blk_x[j];
      ansr = 0; g1 = 0; g2 = 0; g3 = 0;
      if (d == 0) begin
        a = 0;
        run++;
        if (run == 63) begin
          ansr = 128 + 63;
          run = 0;
        end
      end else begin
        if (run > 0) ansr = 128 + run;
        run = 0;
        u = (d >= 0) ? 2 * d : -2 * d - 1;
        q = u / (1 << kk);
        r = u % (1 << kk);
        if (q <= 6) begin
          a = 1;
          f = ((1 << q) - 1) << (7 - q);
          word = f * (1 << kk) + r;
          if (kk == 3) g1 = word;
          else if (kk == 4) g2 = word;
          else g3 = word;
        end else begin
          a = 2;
        end
      end
      exp_q.push_back(pack((j + 1) % 8, a, kk, ansr, g1, g2, g3));
    end
    exp_cout = run;
  endtask

  // driver
  task automatic set_block(input int bv, input int cinv, input int xs [8]);
    blk_b = bv;
    blk_cin = cinv;
    for (int j = 0; j < 8; j++) blk_x[j] = xs[j];
    bus.x1 = 16'(blk_x[0]); bus.x2 = 16'(blk_x[1]);
    bus.x3 = 16'(blk_x[2]); bus.x4 = 16'(blk_x[3]);
    bus.x5 = 16'(blk_x[4]); bus.x6 = 16'(blk_x[5]);
    bus.x7 = 16'(blk_x[6]); bus.x8 = 16'(blk_x[7]);
    bus.b = 16'(blk_b);
    bus.cin = 6'(blk_cin);
    model_block();
  endtask

  task automatic steps(input string name, input int n);
    logic [REC_W-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs_rec[i] = obs_now();
      if (exp_q.size() == 0) begin
        check($sformatf("%s_s%0d_queue", name, i + 1), 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_s%0d", name, i + 1), 64'(obs_rec[i]), 64'(e));
      end
      if (i == 3) check($sformatf("%s_cout_hold", name), 64'(bus.cout), 64'(prev_cout));
      if (i == 7) begin
        check($sformatf("%s_cout", name), 64'(bus.cout), 64'(exp_cout));
        prev_cout = exp_cout;
      end
    end
  endtask

  initial begin
    int amps [4];
    int xs [8];
    int amp, cur;
    amps = '{2, 12, 30, 300};
    n_checks = 0;
    n_fail = 0;
    prev_cout = 0;
    rst_n = 1'b0;
    bus.x1 = '0; bus.x2 = '0; bus.x3 = '0; bus.x4 = '0;
    bus.x5 = '0; bus.x6 = '0; bus.x7 = '0; bus.x8 = '0;
    bus.b = '0; bus.cin = '0;
    repeat (2) @(negedge clk);
    check("reset_rec", 64'(obs_now()), 64'd0);
    check("reset_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;

    // flat block
    set_block(0, 0, '{0, 0, 0, 0, 0, 0, 0, 0});
    steps("flat", 8);
    check("flat_cout_lit", 64'(bus.cout), 64'd8);
    check("flat_k_lit", 64'(obs_rec[0][43:41]), 64'd3);

    // run flush at sample 2
    set_block(10, 5, '{10, 13, 13, 13, 13, 13, 13, 13});
    steps("flush", 8);
    check("flush_ansr_lit", 64'(obs_rec[1][40:33]), 64'b10000110);
    check("flush_a_lit", 64'(obs_rec[1][45:44]), 64'd1);
    check("flush_k_lit", 64'(obs_rec[1][43:41]), 64'd3);
    check("flush_g1_lit", 64'(obs_rec[1][32:23]), 64'b0000000110);
    check("flush_cout_lit", 64'(bus.cout), 64'd6);

    // negative delta, k = 5
    set_block(0, 0, '{-40, 0, -40, 0, -40, 0, -40, 0});
    steps("neg", 8);
    check("neg_k_lit", 64'(obs_rec[0][43:41]), 64'd5);
    check("neg_a_lit", 64'(obs_rec[0][45:44]), 64'd1);
    check("neg_g3_lit", 64'(obs_rec[0][11:0]), 64'b110000001111);

    // escape
    set_block(0, 0, '{60, 60, 60, 60, 60, 60, 60, 60});
    steps("esc", 8);
    check("esc_a_lit", 64'(obs_rec[0][45:44]), 64'd2);
    check("esc_g_lit", 64'(obs_rec[0][32:0]), 64'd0);
    check("esc_k_lit", 64'(obs_rec[0][43:41]), 64'd3);
    check("esc_a2_lit", 64'(obs_rec[1][45:44]), 64'd0);
    check("esc_cout_lit", 64'(bus.cout), 64'd7);

    // run saturation at 63
    set_block(0, 60, '{0, 0, 0, 0, 0, 0, 0, 0});
    steps("sat", 8);
    check("sat_ansr_lit", 64'(obs_rec[2][40:33]), 64'b10111111);
    check("sat_cout_lit", 64'(bus.cout), 64'd5);

    // random blocks with cout fed back as cin
    for (int n = 0; n < 8; n++) begin
      amp = amps[$urandom_range(0, 3)];
      cur = int'($urandom_range(0, 1000)) - 500;
      blk_b = cur;
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(0, 2) != 0) cur = cur + int'($urandom_range(0, 2 * amp)) - amp;
        xs[j] = cur;
      end
      set_block(blk_b, prev_cout, xs);
      steps($sformatf("rnd%0d", n), 8);
    end

    // reset in the middle of a block
    set_block(7, 3, '{7, 7, 9, 9, 9, 5, 5, 5});
    steps("mid", 4);
    rst_n = 1'b0;
    #1;
    check("mid_reset_rec", 64'(obs_now()), 64'd0);
    check("mid_reset_cout", 64'(bus.cout), 64'd0);
    exp_q.delete();
    prev_cout = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_block(0, 2, '{0, 0, 4, 4, -4, -4, 0, 0});
    steps("after_rst", 8);
    check("after_rst_idx_lit", 64'(obs_rec[0][48:46]), 64'd1);
    check("after_rst_ansr_lit", 64'(obs_rec[2][40:33]), 64'b10000100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
